// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared definitions for the two-phase (toggle) CDC handshake:
//                source-side FSM state encoding, default timeout and the
//                timeout-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

   typedef logic [1:0] cdc_state_t;

   localparam cdc_state_t ST_IDLE     = 2'd0;
   localparam cdc_state_t ST_WAIT_ACK = 2'd1;
   localparam cdc_state_t ST_ERROR    = 2'd2;

   localparam int CDC_TIMEOUT_DEFAULT = 1023;

   // Width of a counter able to hold 0..cycles, never narrower than one bit
   // so a disabled timeout (cycles == 0) still yields a legal vector.
   function automatic int cdc_cnt_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : synchronizer
//  Description : Two-flop synchronizer bringing an asynchronous level into
//                the clk domain. Each bit is synchronized independently, so
//                multi-bit use is only safe for gray-coded or toggle signals.
//  Revision    : 1.0 - initial release
//  Ports       : clk   - destination clock
//                rstn  - asynchronous active-low reset (flops clear to 0)
//                d_i   - asynchronous input
//                q_o   - synchronized output, two clk edges of latency
// ============================================================================
module synchronizer #(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH-1:0] meta_q;
   logic [DATA_WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source side of the two-phase (toggle) CDC handshake. Takes a
//                word on a valid/ready interface, holds it on tx_data, toggles
//                tx_req and waits for the matching tx_ack toggle. A watchdog
//                flags a destination that never acknowledges.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rstn         - launching clock, async active-low reset
//                s_valid/s_ready   - upstream handshake, s_data the word
//                tx_req/tx_data    - request toggle and held word to the
//                                    destination domain
//                tx_ack            - acknowledge toggle (asynchronous)
//                tx_done           - one-cycle pulse per completed transfer
//                busy              - transfer outstanding or timed out
//                timeout           - sticky timeout flag
//                timeout_clr       - clears timeout, abandons a timed-out
//                                    transfer
// ============================================================================
module cdc_handshake_tx
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  tx_req,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_ack,
   output logic                  tx_done,
   output logic                  busy,
   output logic                  timeout,
   input  logic                  timeout_clr
);

   localparam int               CNT_W    = cdc_cnt_width(TIMEOUT_CYCLES);
   localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   cdc_state_t            state_q, state_d;
   logic                  req_q,   req_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic                  done_q,  done_d;
   logic                  to_q,    to_d;
   logic                  ack_s;

   synchronizer #(
      .DATA_WIDTH (1)
   ) u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (tx_ack),
      .q_o  (ack_s)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      to_d    = to_q;

      // Clearing the flag is allowed in any state; a timeout raised in the
      // same cycle below still wins so no expiry is lost.
      if (timeout_clr) begin
         to_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               data_d  = s_data;
               req_d   = ~req_q;
               cnt_d   = '0;
               state_d = ST_WAIT_ACK;
            end
         end

         ST_WAIT_ACK: begin
            // Phases equal means the destination has acknowledged; checked
            // first so an ack landing on the final count still completes.
            if (ack_s == req_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               state_d = ST_ERROR;
               to_d    = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_ERROR: begin
            // Abandon the transfer: adopt the destination's phase so the
            // next request toggle is seen as a fresh one.
            if (timeout_clr) begin
               req_d   = ack_s;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   // Decoded from the state register only, never from s_valid.
   assign s_ready = (state_q == ST_IDLE);
   assign busy    = (state_q == ST_WAIT_ACK) || (state_q == ST_ERROR);
   assign tx_req  = req_q;
   assign tx_data = data_q;
   assign tx_done = done_q;
   assign timeout = to_q;

endmodule
`default_nettype wire

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side half of the team's two-phase (toggle) CDC handshake. It accepts a data word on a valid/ready interface, holds it stable on `tx_data`, and toggles `tx_req` to the destination domain. It then waits for the destination's acknowledge toggle, which it brings into its own clock domain through the shared `synchronizer` cell. It sits in the launching clock domain of every multi-bit CDC crossing, opposite the destination-side capture logic. A timeout detects a destination that never acknowledges.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of the transferred word.
- `TIMEOUT_CYCLES`, 1023, number of cycles in WAIT_ACK before the block declares a timeout; 0 disables the timeout.

Ports:
- `clk`  in  1  launching-domain clock.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `s_valid`  in  1  upstream word valid.
- `s_ready`  out  1  block can accept a word.
- `s_data`  in  DATA_WIDTH  upstream word.
- `tx_req`  out  1  request toggle to the destination domain; registered, glitch-free.
- `tx_data`  out  DATA_WIDTH  held word; stable from the req toggle until the ack is observed.
- `tx_ack`  in  1  acknowledge toggle from the destination domain; asynchronous to `clk`.
- `tx_done`  out  1  one-cycle pulse when a transfer completes.
- `busy`  out  1  high in WAIT_ACK and ERROR.
- `timeout`  out  1  sticky timeout flag.
- `timeout_clr`  in  1  clears `timeout` and abandons the pending transfer.

## Operation
- States are IDLE, WAIT_ACK and ERROR. `ack_s` is `tx_ack` after the 2-flop synchronizer.
- In IDLE, `s_ready`=1. On `s_valid & s_ready`:
  - `tx_data` <= `s_data`.
  - `tx_req` <= ~`tx_req`.
  - Timeout counter <= 0.
  - Next state is WAIT_ACK.
- In WAIT_ACK, `s_ready`=0 and `s_valid` is ignored; upstream holds its word.
  - If `ack_s == tx_req`: next state IDLE and `tx_done`=1 for one cycle.
  - Else, if `TIMEOUT_CYCLES != 0` and counter == `TIMEOUT_CYCLES-1`: next state ERROR and `timeout` <= 1.
  - Else the counter increments.
  - If the ack match and the timeout occur in the same cycle, the ack wins.
- In ERROR, `s_ready`=0. `tx_req` and `tx_data` are held.
  - On `timeout_clr`: `tx_req` <= `ack_s` (abandon the transfer and realign the phases), `timeout` <= 0, next state IDLE.
  - An ack that arrives in ERROR has no effect until `timeout_clr`.
- `timeout_clr` in IDLE or WAIT_ACK clears only the flag; the state is unchanged.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` with a minimum of 1. The counter saturates and never wraps.
- `tx_data` updates only on acceptance, never in WAIT_ACK or ERROR.

## Timing
- Reset values:
  - State IDLE, `s_ready`=1.
  - `tx_req`=0, `tx_data`=0.
  - `tx_done`=0, `busy`=0, `timeout`=0.
  - Counter 0; synchronizer flops 0.
- Acceptance at edge T: `tx_req`/`tx_data` change and `busy`=1 from T+1.
- A `tx_ack` toggle that settles before edge A is visible on `ack_s` after edge A+1. The state returns to IDLE and `tx_done` pulses after edge A+2. `s_ready`=1 in the same cycle as `tx_done`.
- Minimum spacing between acceptances is 1 + ack round trip + 2 synchronizer cycles. A new word may be accepted in the `tx_done` cycle.
- `s_ready` and `busy` are decoded directly from the state register, with no combinational path from `s_valid`.
- Reset asserted mid-transfer returns everything to reset values immediately, including `tx_req`=0. The destination must be reset in the same reset domain.

## Structure
- Shared package `cdc_pkg`:
  - State encoding typedef (IDLE=2'd0, WAIT_ACK=2'd1, ERROR=2'd2).
  - Default timeout constant.
- One sub-module: the existing `synchronizer` with DATA_WIDTH=1, used for `tx_ack` → `ack_s`.
- Everything else (FSM, counter, data register) lives in this module.

## Test plan
- Reset: hold `rstn`=0 with random inputs → all outputs at reset values; `s_ready`=1.
- Single transfer: `s_data`=16'hA5C3 accepted at T; testbench toggles `tx_ack` 3 cycles after `tx_req` changes → `tx_data`=16'hA5C3 stable throughout; `tx_done` pulses exactly once, 2 cycles after the ack is sampled; `s_ready` returns to 1.
- Back-to-back: 8 words with `s_valid` held high and a model that acks immediately → 8 `tx_req` toggles, 8 `tx_done` pulses, words in order, none dropped.
- Timeout: ack withheld → `timeout`=1 exactly 1023 cycles after entering WAIT_ACK. An ack that arrives afterwards is ignored. `timeout_clr` → IDLE with `tx_req`==`ack_s` and `timeout`=0.
- Ack/timeout collision: ack timed so that `ack_s` matches in the counter's final cycle → IDLE with `tx_done`=1 and `timeout` stays 0.
- Reset mid-transfer: assert `rstn` in WAIT_ACK → `tx_req`=0 and state IDLE asynchronously. After release, a new transfer completes normally.
